adder_chunk_seq: RTL
====================

// Module: adder_chunk_seq
// PURPOSE
//  Multi-cycle sequencer for wide additions (default 128-bit).
//  Computes f = a + b + cin over NCHUNK = WIDTH/CHUNK cycles on one CHUNK-bit adder slice.
//  Ripples the carry through a register between chunks. Trades latency for area and timing.
//  Sits between registered operand sources and the result consumer; valid/ready on both sides.
// PARAMETERS
//  WIDTH  128  operand/result width in bits
//  CHUNK  32   adder slice width; WIDTH % CHUNK == 0 required (elaboration error otherwise)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to chunk 0
//  out_valid  out  1      f/cOut hold a completed result
//  out_ready  in   1      consumer accepts result
//  f          out  WIDTH  sum (registered)
//  cOut       out  1      carry-out of MSB chunk (registered)
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): state=IDLE, idx=0, carry=0, f=0, cOut=0, out_valid=0.
//  State-derived outputs: in_ready=1 and busy=0 directly after reset.
//  FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
//  IDLE: edge with in_valid=1 -> latch a, b into op regs; carry<=cin; idx<=0; -> RUN.
//    in_valid=0 -> stay. a/b/cin are sampled only on this edge; later changes have no effect.
//  RUN, each edge:
//    {c,s} = opA[idx*CHUNK +: CHUNK] + opB[idx*CHUNK +: CHUNK] + carry.
//    f[idx chunk] <= s; carry <= c; idx <= idx+1.
//    When idx == NCHUNK-1: also cOut <= c; idx <= 0; -> DONE.
//  DONE: f/cOut held stable; out_ready=1 -> IDLE, out_ready=0 -> stay indefinitely.
//  Latency: acceptance edge E; out_valid rises after edge E+NCHUNK. Both flags are state-derived,
//    so a DONE->IDLE edge cannot accept; minimum period between accepts is NCHUNK+2 cycles.
//  in_valid while in_ready=0 is ignored; the source must hold it until accepted.
//  f bits not yet written by RUN hold the previous result; f and cOut are only valid while out_valid=1.
//  Arithmetic: modulo 2^WIDTH; cOut = bit WIDTH of the full WIDTH+1-bit sum.
//  Chunk carry width: CHUNK+1 bits.
//  Reset mid-RUN/DONE: operation abandoned, no result emitted, back to reset values.
//  NCHUNK=1: single RUN cycle, latency 1.
//  idx width: max(1,$clog2(NCHUNK)).
// TESTING
//  T1 reset: assert rst mid-RUN (idx=2) -> next cycle out_valid=0, in_ready=1, f=0, cOut=0; no stale result.
//  T2 full ripple: a=128'hFFFF..FF, b=1, cin=0 -> f=0, cOut=1, out_valid 4 cycles after accept.
//  T3 chunk boundary: a=128'h0000_FFFF_FFFF, b=1, cin=0 -> f=128'h1_0000_0000, cOut=0.
//    cin=1, a=b=0 -> f=1.
//  T4 backpressure: out_ready=0 for 10 cycles in DONE -> f/cOut stable, out_valid=1, in_ready=0.
//    New in_valid ignored; then out_ready=1 -> IDLE next edge.
//  T5 streaming: in_valid=out_ready=1 constantly -> one accept every 6 cycles at defaults.
//    Results in order.
//  T6 random: 1000 ops vs {cOut,f}==a+b+cin model, for CHUNK=32, 128 (NCHUNK=1), 8.
//    Random in_valid/out_ready.

Source files
------------

// File: rtl/adder_chunk_seq.sv
// Multi-cycle wide adder: f = a + b + cin, computed one CHUNK-bit slice per cycle with a registered carry.
// Latency: operands accepted on edge E, out_valid rises after edge E+NCHUNK; accept-to-accept >= NCHUNK+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, for as long as needed.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake for a, b, cin (sampled only on the accept edge)
//   out_valid/out_ready result handshake for f, cOut (both registered)
//   busy                high whenever the sequencer is not idle
module adder_chunk_seq #(
   parameter int WIDTH = 128,
   parameter int CHUNK = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             cOut,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   // The slice adder only makes sense when the operand splits into whole chunks.
   if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("adder_chunk_seq: WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDXW-1:0]   r_idx;
   logic              r_carry;
   logic [WIDTH-1:0]  r_op_a;
   logic [WIDTH-1:0]  r_op_b;
   logic [WIDTH-1:0]  r_f;
   logic              r_cout;

   logic [CHUNK-1:0]  w_a_chunk;
   logic [CHUNK-1:0]  w_b_chunk;
   logic [CHUNK:0]    w_sum;
   logic              w_last;

   // One shared slice adder; the top bit of w_sum is the carry into the next chunk.
   assign w_a_chunk = r_op_a[r_idx*CHUNK +: CHUNK];
   assign w_b_chunk = r_op_b[r_idx*CHUNK +: CHUNK];
   assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
   assign w_last    = (r_idx == LAST_IDX);

   // Handshake flags come straight from the state so no input can combinationally reach an output.
   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign f         = r_f;
   assign cOut      = r_cout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_f     <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op_a  <= a;
                  r_op_b  <= b;
                  r_carry <= cin;
                  r_idx   <= '0;
               end
            end
            S_RUN: begin
               r_f[r_idx*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
               r_carry                   <= w_sum[CHUNK];
               if (w_last) begin
                  r_cout <= w_sum[CHUNK];
                  r_idx  <= '0;
               end else begin
                  r_idx  <= r_idx + IDXW'(1);
               end
            end
            default: begin
               // DONE: result registers hold until the consumer takes them.
            end
         endcase
      end
   end

endmodule
